mm_mem_responder: RTL and testbench

- Memory-side responder for the matmul datapath's memory port: it accepts the datapath's address/write-data requests and returns read data.
- Backed by a word-addressed internal array that holds input matrix 1, input matrix 2 and the output matrix.
- Provides a fixed-latency read pipeline, single-cycle writes, alignment/range checking, and a sequential clear engine used to zero the output region before accumulation.

---
 rtl/mm_mem_pkg.sv | 26 ++
 rtl/mm_rd_pipe.sv | 54 +++++
 rtl/mm_mem_responder.sv | 147 ++++++++++++++
 tb/tb_mm_mem_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_mem_pkg.sv
// Shared definitions for the matmul memory responder: default widths,
// the clear-engine state encoding and byte-address to word-index helpers.
package mm_mem_pkg;

    localparam int ADDR_W_DEF = 24;
    localparam int DATA_W_DEF = 24;
    localparam int DEPTH_DEF  = 1024;
    localparam int RD_LAT_DEF = 2;
    localparam int CLR_LEN_W  = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    // Byte address to word index; callers truncate to their index width.
    function automatic logic [63:0] word_index(input logic [63:0] addr);
        return addr >> 2;
    endfunction

    // An access is legal when it is word-aligned and lands inside the array.
    function automatic logic addr_is_legal(input logic [63:0] addr, input int unsigned depth);
        return (addr[1:0] == 2'b00) && (word_index(addr) < 64'(depth));
    endfunction

endpackage

// File: rtl/mm_rd_pipe.sv
// Fixed-latency read return pipeline. Valid bits always shift; each data
// stage only loads when a valid word arrives, so the last stage holds the
// most recent returned word while no read is completing.
module mm_rd_pipe #(
    parameter int LAT    = 2,
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [LAT-1:0]    valid_q, valid_d;
    logic [DATA_W-1:0] data_q [LAT];
    logic [DATA_W-1:0] data_d [LAT];

    // Next-stage values: shift valids, move data only alongside a valid.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        valid_d[0] = in_valid;
        if (in_valid) begin
            data_d[0] = in_data;
        end
        for (int i = 1; i < LAT; i++) begin
            valid_d[i] = valid_q[i-1];
            if (valid_q[i-1]) begin
                data_d[i] = data_q[i-1];
            end
        end
    end

    // Stage registers; reset drops every in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < LAT; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign out_valid = valid_q[LAT-1];
    assign out_data  = data_q[LAT-1];

endmodule

// File: rtl/mm_mem_responder.sv
// Memory-side responder for the matmul datapath: word array holding both
// input matrices and the output matrix, fixed-latency reads, single-cycle
// writes, alignment/range checking and a one-word-per-cycle clear engine.
//
// Handshake: a request (req, we, addr_mem, din_mem) is taken on any rising
// edge where req && ready. ready is low only while the clear engine runs.
// Writes return nothing; every accepted read, legal or not, returns exactly
// one rvalid pulse RD_LAT cycles later, in acceptance order. rvalid has no
// back-pressure: the requester must take the data in the cycle it appears.
module mm_mem_responder
    import mm_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    addr_mem,
    input  logic [DATA_W-1:0]    din_mem,
    output logic [DATA_W-1:0]    dout_mem,
    output logic                 rvalid,
    output logic                 ready,
    output logic                 err,
    input  logic                 clr_start,
    input  logic [ADDR_W-1:0]    clr_base,
    input  logic [CLR_LEN_W-1:0] clr_len,
    output logic                 clr_done
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [CLR_LEN_W-1:0] cnt_q, cnt_d;
    logic                 ready_q, ready_d;
    logic                 clr_done_q, clr_done_d;
    logic                 err_q, err_d;

    logic                 accept;
    logic                 legal;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     clr_base_idx;
    logic                 wr_en;
    logic                 clr_wr;
    logic                 rd_valid_in;
    logic [DATA_W-1:0]    rd_data_in;

    // Request decode: acceptance, legality and the word read at acceptance.
    // Illegal reads still enter the pipe, carrying zero data.
    always_comb begin
        accept       = req && ready_q;
        legal        = addr_is_legal(64'(addr_mem), DEPTH);
        idx          = IDX_W'(word_index(64'(addr_mem)));
        wr_en        = accept && we && legal;
        rd_valid_in  = accept && !we;
        rd_data_in   = legal ? mem[idx] : '0;
        err_d        = accept && !legal;
        // Low address bits are dropped, so a misaligned base rounds down and
        // bits above the array wrap modulo DEPTH.
        clr_base_idx = IDX_W'(word_index(64'(clr_base)));
        clr_wr       = (state_q == CLEAR);
    end

    // Clear engine next-state: load pointer/count on start, then walk one
    // word per cycle until the count runs out.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        clr_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    if (clr_len != '0) begin
                        state_d = CLEAR;
                        ptr_d   = clr_base_idx;
                        cnt_d   = clr_len;
                    end else begin
                        clr_done_d = 1'b1;
                    end
                end
            end
            CLEAR: begin
                // clr_start is deliberately not looked at here.
                ptr_d = ptr_q + IDX_W'(1);
                cnt_d = cnt_q - CLR_LEN_W'(1);
                if (cnt_q == CLR_LEN_W'(1)) begin
                    state_d    = IDLE;
                    clr_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    // FSM state and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            ready_q    <= 1'b1;
            clr_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            clr_done_q <= clr_done_d;
            err_q      <= err_d;
        end
    end

    // Array write port; clear and requests never overlap since ready=0 in CLEAR.
    always_ff @(posedge clk) begin
        if (clr_wr) begin
            mem[ptr_q] <= '0;
        end else if (wr_en) begin
            mem[idx] <= din_mem;
        end
    end

    mm_rd_pipe #(
        .LAT    (RD_LAT),
        .DATA_W (DATA_W)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_valid_in),
        .in_data   (rd_data_in),
        .out_valid (rvalid),
        .out_data  (dout_mem)
    );

    assign ready    = ready_q;
    assign err      = err_q;
    assign clr_done = clr_done_q;

endmodule

// File: tb/tb_mm_mem_responder.sv
// Directed bench for mm_mem_responder (DEPTH=1024, RD_LAT=2).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_mm_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [23:0] addr_mem;
    logic [23:0] din_mem;
    logic [23:0] dout_mem;
    logic        rvalid;
    logic        ready;
    logic        err;
    logic        clr_start;
    logic [23:0] clr_base;
    logic [15:0] clr_len;
    logic        clr_done;

    int checks = 0;
    int errors = 0;
    logic [23:0] exp_q[$];

    mm_mem_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .addr_mem  (addr_mem),
        .din_mem   (din_mem),
        .dout_mem  (dout_mem),
        .rvalid    (rvalid),
        .ready     (ready),
        .err       (err),
        .clr_start (clr_start),
        .clr_base  (clr_base),
        .clr_len   (clr_len),
        .clr_done  (clr_done)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [23:0] a, input logic [23:0] d, input logic exp_err, input string tag);
        req = 1'b1; we = 1'b1; addr_mem = a; din_mem = d;
        tick();
        req = 1'b0; we = 1'b0;
        check({tag, "_err"}, err, exp_err);
    endtask

    task automatic read_check(input logic [23:0] a, input logic [23:0] exp_d, input logic exp_err, input string tag);
        req = 1'b1; we = 1'b0; addr_mem = a;
        tick();
        req = 1'b0;
        check({tag, "_err"}, err, exp_err);
        check({tag, "_early_rv"}, rvalid, 1'b0);
        tick();
        check({tag, "_rv"}, rvalid, 1'b1);
        check({tag, "_data"}, dout_mem, exp_d);
        check({tag, "_err_end"}, err, 1'b0);
    endtask

    task automatic run_clear(input logic [23:0] base, input logic [15:0] len, input string tag);
        int busy;
        logic seen;
        busy = 0;
        seen = 1'b0;
        clr_start = 1'b1; clr_base = base; clr_len = len;
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (clr_done) begin
                seen = 1'b1;
                break;
            end
            if (!ready) busy++;
            tick();
        end
        check({tag, "_done_seen"}, seen, 1'b1);
        check({tag, "_busy_cycles"}, busy, 32'(len));
        check({tag, "_ready_at_done"}, ready, 1'b1);
        tick();
        check({tag, "_done_pulse"}, clr_done, 1'b0);
    endtask

    // Directed sequence
    initial begin
        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr_mem = '0; din_mem = '0;
        clr_start = 1'b0; clr_base = '0; clr_len = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        check("rst_dout", dout_mem, 24'h0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_clr_done", clr_done, 1'b0);
        check("rst_ready", ready, 1'b1);
        tick();

        // 1: write then read, latency 2
        do_write(24'h000010, 24'h00ABCD, 1'b0, "t1_wr");
        read_check(24'h000010, 24'h00ABCD, 1'b0, "t1_rd");
        tick();
        check("t1_rv_drop", rvalid, 1'b0);
        check("t1_dout_hold", dout_mem, 24'h00ABCD);

        // 2: back-to-back reads return in order on consecutive cycles
        do_write(24'h0, 24'd1, 1'b0, "t2_wr0");
        do_write(24'h4, 24'd2, 1'b0, "t2_wr1");
        do_write(24'h8, 24'd3, 1'b0, "t2_wr2");
        for (int i = 0; i < 3; i++) begin
            check("t2_ready", ready, 1'b1);
            req = 1'b1; we = 1'b0; addr_mem = 24'(4 * i);
            exp_q.push_back(24'(i + 1));
            tick();
            if (i >= 1) begin
                check("t2_rv", rvalid, 1'b1);
                check("t2_data", dout_mem, exp_q.pop_front());
            end
        end
        req = 1'b0;
        tick();
        check("t2_rv_last", rvalid, 1'b1);
        check("t2_data_last", dout_mem, exp_q.pop_front());
        tick();
        check("t2_rv_idle", rvalid, 1'b0);
        check("t2_queue_empty", exp_q.size(), 0);

        // 3: illegal accesses
        read_check(24'h000006, 24'h0, 1'b1, "t3_rd_misal");
        read_check(24'h001000, 24'h0, 1'b1, "t3_rd_range");
        do_write(24'h000006, 24'h777777, 1'b1, "t3_wr_misal");
        do_write(24'h001000, 24'h777777, 1'b1, "t3_wr_range");
        tick();
        check("t3_err_pulse", err, 1'b0);
        read_check(24'h000004, 24'd2, 1'b0, "t3_keep1");
        read_check(24'h000000, 24'd1, 1'b0, "t3_keep0");

        // 4: clear 8 words at 0x100; restart during CLEAR must be ignored
        for (int i = 0; i < 8; i++) begin
            do_write(24'(24'h100 + 4 * i), 24'hFFFFFF, 1'b0, "t4_pre");
        end
        do_write(24'h000120, 24'h123456, 1'b0, "t4_pre_nb");
        clr_start = 1'b1; clr_base = 24'h000100; clr_len = 16'd8;
        tick();
        clr_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("t4_busy_ready", ready, 1'b0);
            check("t4_busy_done", clr_done, 1'b0);
            if (k == 3) begin
                clr_start = 1'b1; clr_base = 24'h000120; clr_len = 16'd2;
            end
            tick();
            clr_start = 1'b0;
        end
        check("t4_ready_back", ready, 1'b1);
        check("t4_done", clr_done, 1'b1);
        tick();
        check("t4_done_pulse", clr_done, 1'b0);
        for (int i = 0; i < 8; i++) begin
            read_check(24'(24'h100 + 4 * i), 24'h0, 1'b0, "t4_zero");
        end
        read_check(24'h000120, 24'h123456, 1'b0, "t4_neighbor");

        // 5: wrap-around clear from a misaligned base near the top, then len 0
        do_write(24'h000FF8, 24'hAAAAA1, 1'b0, "t5_pre");
        do_write(24'h000FFC, 24'hAAAAA2, 1'b0, "t5_pre");
        do_write(24'h000000, 24'hAAAAA3, 1'b0, "t5_pre");
        do_write(24'h000004, 24'hAAAAA4, 1'b0, "t5_pre");
        do_write(24'h000008, 24'h555555, 1'b0, "t5_pre");
        run_clear(24'h000FFB, 16'd4, "t5_wrap");
        read_check(24'h000FF8, 24'h0, 1'b0, "t5_w1022");
        read_check(24'h000FFC, 24'h0, 1'b0, "t5_w1023");
        read_check(24'h000000, 24'h0, 1'b0, "t5_w0");
        read_check(24'h000004, 24'h0, 1'b0, "t5_w1");
        read_check(24'h000008, 24'h555555, 1'b0, "t5_w2");
        run_clear(24'h000008, 16'd0, "t5_len0");
        read_check(24'h000008, 24'h555555, 1'b0, "t5_len0_keep");

        // 6: reads overlapping clear start, then reset 3 cycles into the clear
        for (int i = 0; i < 16; i++) begin
            do_write(24'(24'h200 + 4 * i), 24'(24'h100000 + i), 1'b0, "t6_pre");
        end
        req = 1'b1; we = 1'b0; addr_mem = 24'h000200;
        tick();
        addr_mem = 24'h00020C;
        clr_start = 1'b1; clr_base = 24'h000200; clr_len = 16'd16;
        tick();
        req = 1'b0; clr_start = 1'b0;
        check("t6_ready_low", ready, 1'b0);
        check("t6_rd0_rv", rvalid, 1'b1);
        check("t6_rd0_data", dout_mem, 24'h100000);
        tick();
        check("t6_rd1_rv", rvalid, 1'b1);
        check("t6_rd1_data", dout_mem, 24'h100003);
        tick();
        check("t6_rv_quiet", rvalid, 1'b0);
        check("t6_still_busy", ready, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        check("t6_rst_ready", ready, 1'b1);
        check("t6_rst_dout", dout_mem, 24'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_post_ready", ready, 1'b1);
        check("t6_post_done", clr_done, 1'b0);
        check("t6_post_rv", rvalid, 1'b0);
        for (int i = 0; i < 16; i++) begin
            read_check(24'(24'h200 + 4 * i), (i < 3) ? 24'h0 : 24'(24'h100000 + i), 1'b0, "t6_word");
        end

        // 7: reset drops an in-flight read
        req = 1'b1; we = 1'b0; addr_mem = 24'h000214;
        tick();
        req = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t7_no_rv_rst", rvalid, 1'b0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t7_no_rv_post", rvalid, 1'b0);
        end
        read_check(24'h000214, 24'h100005, 1'b0, "t7_rd_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
